bcd_mod_counter: RTL
====================

# bcd_mod_counter

Parametrised N-digit BCD modulo counter, the generalised successor to the fixed two-digit 00–59 time counters. One instance counts seconds or minutes (MODULUS=60), hours (MODULUS=24), or any BCD range up to 10^DIGITS. It adds a count direction, a validated parallel load, and a carry/borrow output that is qualified by the incoming enable, so instances chain directly (sec → min → hour) with no external gating.

## Interface
- DIGITS, 2, number of BCD digits (1..4)
- MODULUS, 60, count range 0..MODULUS-1 (2..10^DIGITS)
- DEF_VALUE, 0, reset value, binary integer < MODULUS, stored as BCD

- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- carry_in  in  1  count enable for this cycle; driven by the upstream carry_out
- down  in  1  0 = count up, 1 = count down
- load  in  1  parallel-load strobe
- load_value  in  4*DIGITS  BCD load value, digit 0 in bits [3:0]
- value  out  4*DIGITS  current count, BCD, digit 0 in bits [3:0]
- carry_out  out  1  combinational; wrap event this cycle (carry when counting up, borrow when counting down)
- at_terminal  out  1  combinational; value equals the terminal value for the current direction
- load_err  out  1  registered; one-cycle pulse when a load is rejected

## Operation
- Priority per cycle: rst > load > carry_in > hold.
- rst: value = BCD(DEF_VALUE), load_err = 0.
- Terminal value: MODULUS-1 when down = 0, 0 when down = 1. at_terminal compares against the current down.
- Count, up (carry_in = 1, down = 0):
  - At the terminal value, wrap to 0.
  - Otherwise increment in BCD. A digit at 9 becomes 0 and carries into the next digit.
- Count, down (carry_in = 1, down = 1):
  - At 0, wrap to MODULUS-1.
  - Otherwise decrement in BCD. A digit at 0 becomes 9 and borrows from the next digit.
- carry_out = carry_in & at_terminal & ~load & ~rst. It never asserts while merely sitting at the terminal value without an enable.
- Load validation:
  - Accepted only if every digit is ≤ 9 and the decoded value is < MODULUS.
  - Accepted load: value = load_value next edge, load_err = 0.
  - Rejected load: value holds, load_err = 1 for one cycle.
  - A rejected load still takes priority over carry_in; the count enable is dropped that cycle.
- Digits above the MODULUS range are held at 0. Internal state is never non-BCD.
- Changing down takes effect on the same cycle for at_terminal/carry_out and on the next edge for value.

## Timing
- value: registered, updates on the edge where carry_in or an accepted load is sampled. Count latency is 1 cycle.
- carry_out / at_terminal: combinational from value, carry_in, down, load, rst. carry_out and the wrap occur in the same cycle, so a chained counter advances on the same edge.
- load_err: registered, asserted the cycle after the offending load, cleared the following cycle unless the load is repeated.
- Reset mid-operation: counting, a pending load, or a load_err pulse are all discarded on the edge where rst = 1.
- Back-to-back carry_in every cycle is supported; no dead cycles at wrap.
- Critical path: DIGITS-deep digit carry chain plus terminal compare. DIGITS ≤ 4 must meet the board clock.

## Test plan
- MODULUS=60, DEF_VALUE=0: load 0x58, carry_in high 3 cycles → value 0x59, 0x00, 0x01. carry_out high only in the cycle value = 0x59.
- MODULUS=24: from 0x19, carry_in ×5 → 0x20, 0x21, 0x22, 0x23, 0x00. No 0x24 ever appears; carry_out pulses at 0x23.
- MODULUS=60, down=1: load 0x00, carry_in → value 0x59 with carry_out high in the 0x00 cycle. Then 0x10 → 0x09 (digit borrow).
- Invalid loads on MODULUS=60 at value 0x33: load_value 0x7A, then 0x60 → value stays 0x33, load_err pulses 1 cycle each. Load 0x45 → value 0x45, load_err 0.
- Simultaneous events: load=1 (0x12) with carry_in=1 at value 0x59 → value 0x12, carry_out 0. rst=1 with load=1 → value = DEF_VALUE.
- Chain sec (60) → min (60) → hour (24), sec.carry_in tied 1, start at 23:59:58 → 23:59:59 then 00:00:00 on the same edge. All three carry_outs are high in the 23:59:59 cycle.

Source files
------------

// File: rtl/bcd_mod_counter_if.sv
// Bus for one BCD modulo counter: count/load controls in, count and status out.
// master = the side driving the controls, slave = the counter itself.
interface bcd_mod_counter_if #(
  parameter int DIGITS = 2
);
  logic                  carry_in;
  logic                  down;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   value;
  logic                  carry_out;
  logic                  at_terminal;
  logic                  load_err;

  modport master (
    output carry_in, down, load, load_value,
    input  value, carry_out, at_terminal, load_err
  );

  modport slave (
    input  carry_in, down, load, load_value,
    output value, carry_out, at_terminal, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// N-digit BCD up/down modulo counter with validated parallel load and an
// enable-qualified carry/borrow so instances chain directly (sec -> min -> hour).
module bcd_mod_counter #(
  parameter int DIGITS    = 2,
  parameter int MODULUS   = 60,
  parameter int DEF_VALUE = 0
) (
  input  logic                clk,
  input  logic                rst,
  bcd_mod_counter_if.slave    bus
);
  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    int rem;
    rem    = v;
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(rem % 10);
      rem              = rem / 10;
    end
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);
  localparam logic [W-1:0] DEF_BCD = to_bcd(DEF_VALUE);

  logic [W-1:0]      r_value;
  logic              r_load_err;

  logic [W-1:0]      w_inc;
  logic [W-1:0]      w_dec;
  logic [DIGITS-1:0] w_cy;
  logic [DIGITS-1:0] w_bw;
  logic [DIGITS-1:0] w_dig_ok;
  logic              w_load_ok;
  logic              w_at_term;

  assign w_cy[0] = 1'b1;
  assign w_bw[0] = 1'b1;

  // Ripple increment/decrement across digits; this chain is the critical path.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] w_d;
    assign w_d = r_value[4*g +: 4];
    assign w_inc[4*g +: 4] = !w_cy[g] ? w_d : ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1);
    assign w_dec[4*g +: 4] = !w_bw[g] ? w_d : ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
    assign w_dig_ok[g]     = (bus.load_value[4*g +: 4] <= 4'd9);
    if (g < DIGITS - 1) begin : g_nxt
      assign w_cy[g+1] = w_cy[g] & (w_d == 4'd9);
      assign w_bw[g+1] = w_bw[g] & (w_d == 4'd0);
    end
  end

  // With every digit valid, packed BCD orders the same as the binary value,
  // so the range check is a plain unsigned compare against MODULUS-1.
  assign w_load_ok = (&w_dig_ok) && (bus.load_value <= MAX_BCD);

  assign w_at_term = bus.down ? (r_value == '0) : (r_value == MAX_BCD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value    <= DEF_BCD;
      r_load_err <= 1'b0;
    end else if (bus.load) begin
      if (w_load_ok) begin
        r_value    <= bus.load_value;
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= 1'b1;
      end
    end else begin
      r_load_err <= 1'b0;
      if (bus.carry_in) begin
        if (w_at_term)
          r_value <= bus.down ? MAX_BCD : '0;
        else
          r_value <= bus.down ? w_dec : w_inc;
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.load_err    = r_load_err;
  assign bus.at_terminal = w_at_term;
  assign bus.carry_out   = bus.carry_in & w_at_term & ~bus.load & ~rst;
endmodule
